// File: rtl/tk1_mem_map_pkg.sv
// Memory-map constants shared by the CPU bus decoder: address prefixes,
// trap response word, default target decode tables and FSM state encodings.
package tk1_mem_map_pkg;

    localparam logic [1:0] ROM_AREA      = 2'b00;
    localparam logic [1:0] RAM_AREA      = 2'b01;
    localparam logic [1:0] RESERVED_AREA = 2'b10;
    localparam logic [1:0] MMIO_AREA     = 2'b11;

    localparam logic [7:0] ROM_PREFIX    = 8'h00;
    localparam logic [7:0] RAM_PREFIX    = 8'h40;
    localparam logic [7:0] TRNG_PREFIX   = 8'hc0;
    localparam logic [7:0] TIMER_PREFIX  = 8'hc1;
    localparam logic [7:0] UDS_PREFIX    = 8'hc2;
    localparam logic [7:0] UART_PREFIX   = 8'hc3;
    localparam logic [7:0] TOUCH_PREFIX  = 8'hc4;
    localparam logic [7:0] FW_RAM_PREFIX = 8'hd0;
    localparam logic [7:0] TK1_PREFIX    = 8'hff;

    localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0000_0000;

    // Target 0 sits in the least significant byte.
    localparam logic [71:0] DEFAULT_TGT_MATCH = {
        TK1_PREFIX, FW_RAM_PREFIX, TOUCH_PREFIX, UART_PREFIX, UDS_PREFIX,
        TIMER_PREFIX, TRNG_PREFIX, RAM_PREFIX, ROM_PREFIX
    };
    localparam logic [71:0] DEFAULT_TGT_MASK = {{7{8'hff}}, 8'hc0, 8'hc0};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/bus_timeout.sv
// Wait-cycle counter for the bus decoder; only instantiated when
// BUS_DECODER_TIMEOUT_EN is defined. Count restarts at 0 on every WAIT entry.
module bus_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!count_en) begin
            count <= '0;
        end else if (count != 16'hffff) begin
            count <= count + 16'd1;
        end
    end

    assign expired = count_en && (count == 16'(LIMIT));

endmodule

// File: rtl/bus_decoder.sv
// CPU bus decoder: address-prefix target select, ready/trap/error response FSM.
// Optional wait timeout enabled with BUS_DECODER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no access outstanding, decode a new cpu_valid
// WAIT    | selected target not yet ready, keep tgt_cs asserted
// RESP    | one-cycle cpu_ready pulse, all tgt_cs low
module bus_decoder
    import tk1_mem_map_pkg::*;
#(
    parameter int NUM_TARGETS = 9,
    parameter logic [NUM_TARGETS*8-1:0] TGT_MATCH = DEFAULT_TGT_MATCH,
    parameter logic [NUM_TARGETS*8-1:0] TGT_MASK  = DEFAULT_TGT_MASK,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cpu_valid,
    input  logic [31:0]               cpu_addr,
    input  logic [3:0]                cpu_wstrb,
    input  logic                      force_trap,
    output logic                      cpu_ready,
    output logic [31:0]               cpu_rdata,
    output logic [NUM_TARGETS-1:0]    tgt_cs,
    output logic [3:0]                tgt_we,
    input  logic [NUM_TARGETS*32-1:0] tgt_rdata,
    input  logic [NUM_TARGETS-1:0]    tgt_ready,
    output logic                      bus_error,
    output logic [31:0]               err_addr
);

    logic [1:0]  state;
    logic        hit;
    logic [3:0]  sel;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        active;
    logic        timeout_hit;

    // Descending scan so the lowest matching index is the one left in sel.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if ((cpu_addr[31:24] & TGT_MASK[i*8 +: 8]) ==
                (TGT_MATCH[i*8 +: 8] & TGT_MASK[i*8 +: 8])) begin
                hit = 1'b1;
                sel = 4'(i);
            end
        end
    end

    assign sel_ready = tgt_ready[sel];
    assign sel_rdata = tgt_rdata[sel*32 +: 32];
    assign active    = cpu_valid && ((state == ST_IDLE) || (state == ST_WAIT));

    always_comb begin
        tgt_cs = '0;
        if (reset_n && active && !force_trap && hit) begin
            tgt_cs[sel] = 1'b1;
        end
    end

    assign tgt_we = (|tgt_cs) ? cpu_wstrb : 4'h0;

`ifdef BUS_DECODER_TIMEOUT_EN
    logic expired;

    bus_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_bus_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (state == ST_WAIT),
        .expired  (expired)
    );

    assign timeout_hit = expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // Response priority: trap, unmapped, target ready, timeout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            bus_error <= 1'b0;
            err_addr  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (!cpu_valid) begin
                        state <= ST_IDLE;
                    end else if (force_trap) begin
                        cpu_rdata <= ILLEGAL_INSTRUCTION;
                        cpu_ready <= 1'b1;
                        state     <= ST_RESP;
                    end else if (!hit || timeout_hit) begin
                        if (hit && sel_ready) begin
                            cpu_rdata <= sel_rdata;
                        end else begin
                            cpu_rdata <= '0;
                            bus_error <= 1'b1;
                            err_addr  <= cpu_addr;
                        end
                        cpu_ready <= 1'b1;
                        state     <= ST_RESP;
                    end else if (sel_ready) begin
                        cpu_rdata <= sel_rdata;
                        cpu_ready <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed scenarios plus randomized
// transactions checked against a table-driven decode/response model.
module tb_bus_decoder;

    localparam int NT = 9;
    localparam int TO = 4;
    localparam int MATCH_T [NT] = '{'h00, 'h40, 'hc0, 'hc1, 'hc2, 'hc3, 'hc4, 'hd0, 'hff};
    localparam int MASK_T  [NT] = '{'hc0, 'hc0, 'hff, 'hff, 'hff, 'hff, 'hff, 'hff, 'hff};

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_valid;
    logic [31:0]       cpu_addr;
    logic [3:0]        cpu_wstrb;
    logic              force_trap;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic [NT-1:0]     tgt_cs;
    logic [3:0]        tgt_we;
    logic [NT*32-1:0]  tgt_rdata;
    logic [NT-1:0]     tgt_ready;
    logic              bus_error;
    logic [31:0]       err_addr;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_rdata;
    logic [31:0] exp_err_addr;

    bus_decoder #(
        .NUM_TARGETS    (NT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_wstrb  (cpu_wstrb),
        .force_trap (force_trap),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .tgt_cs     (tgt_cs),
        .tgt_we     (tgt_we),
        .tgt_rdata  (tgt_rdata),
        .tgt_ready  (tgt_ready),
        .bus_error  (bus_error),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        int top;
        top = int'(a[31:24]);
        for (int i = 0; i < NT; i++) begin
            if ((top & MASK_T[i]) == (MATCH_T[i] & MASK_T[i])) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access; delay = cycles the selected target keeps ready low.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                           input bit trap, input int delay);
        int idx;
        int ncyc;
        logic [NT-1:0] exp_cs;
        logic [31:0] words [NT];
        bit exp_err;
        idx = ref_decode(addr);
        for (int i = 0; i < NT; i++) begin
            words[i] = $urandom;
            tgt_rdata[i*32 +: 32] = words[i];
        end
        cpu_valid  = 1'b1;
        cpu_addr   = addr;
        cpu_wstrb  = wstrb;
        force_trap = trap;
        exp_err    = !trap && (idx < 0);
        exp_cs     = '0;
        ncyc       = 1;
        if (trap || idx < 0) begin
            exp_rdata = 32'h0;
        end else begin
            exp_cs    = NT'(1 << idx);
            ncyc      = delay + 1;
            exp_rdata = words[idx];
        end
        if (exp_err) exp_err_addr = addr;
        for (int c = 0; c < ncyc; c++) begin
            tgt_ready = NT'($urandom);
            if (idx >= 0) tgt_ready[idx] = trap ? 1'b1 : (c == delay);
            @(negedge clk);
            check("tgt_cs", 64'(tgt_cs), 64'(exp_cs));
            check("tgt_we", 64'(tgt_we), 64'((exp_cs != '0) ? wstrb : 4'h0));
            check("ready_early", 64'(cpu_ready), 64'(0));
            tick();
        end
        cpu_valid  = 1'b0;
        force_trap = 1'b0;
        tgt_ready  = NT'($urandom);
        @(negedge clk);
        check("resp_ready", 64'(cpu_ready), 64'(1));
        check("resp_rdata", 64'(cpu_rdata), 64'(exp_rdata));
        check("resp_error", 64'(bus_error), 64'(exp_err));
        check("resp_err_addr", 64'(err_addr), 64'(exp_err_addr));
        check("resp_cs", 64'(tgt_cs), 64'(0));
        tick();
        @(negedge clk);
        check("post_ready", 64'(cpu_ready), 64'(0));
        check("post_error", 64'(bus_error), 64'(0));
        check("hold_rdata", 64'(cpu_rdata), 64'(exp_rdata));
        tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 64'(cpu_ready), 64'(0));
        check({tag, "_rdata"}, 64'(cpu_rdata), 64'(0));
        check({tag, "_error"}, 64'(bus_error), 64'(0));
        check({tag, "_err_addr"}, 64'(err_addr), 64'(0));
        check({tag, "_cs"}, 64'(tgt_cs), 64'(0));
        check({tag, "_we"}, 64'(tgt_we), 64'(0));
    endtask

    initial begin
        int pulses;
        int seen;
        logic [7:0] top;
        int t;

        reset_n    = 1'b0;
        cpu_valid  = 1'b0;
        cpu_addr   = '0;
        cpu_wstrb  = '0;
        force_trap = 1'b0;
        tgt_rdata  = '0;
        tgt_ready  = '0;
        exp_rdata    = 32'h0;
        exp_err_addr = 32'h0;
        repeat (3) tick();
        @(negedge clk);
        check_zero_outputs("reset");
        tick();
        reset_n = 1'b1;
        tick();

        run_txn(32'hC300_0004, 4'h0, 1'b0, 0);
        run_txn(32'h4000_0010, 4'hF, 1'b0, 3);
        run_txn(32'hC500_0000, 4'h0, 1'b0, 0);
        run_txn(32'h0000_0100, 4'h0, 1'b1, 0);
        run_txn(32'h3F00_0000, 4'h3, 1'b0, 1);
        run_txn(32'hFF00_0008, 4'h0, 1'b0, 2);

        // Request abandoned while waiting: no response at all.
        cpu_valid = 1'b1;
        cpu_addr  = 32'h4000_0000;
        cpu_wstrb = 4'h0;
        tgt_ready = '0;
        repeat (3) tick();
        cpu_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cpu_ready || bus_error || (tgt_cs != '0)) pulses++;
            tick();
        end
        check("drop_in_wait", 64'(pulses), 64'(0));

        // Target that never answers.
        cpu_valid = 1'b1;
        cpu_addr  = 32'h4000_0020;
        tgt_ready = '0;
`ifdef BUS_DECODER_TIMEOUT_EN
        seen = -1;
        for (int c = 0; c < 12 && seen < 0; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                seen = c;
                check("timeout_rdata", 64'(cpu_rdata), 64'(0));
                check("timeout_error", 64'(bus_error), 64'(1));
                check("timeout_err_addr", 64'(err_addr), 64'(32'h4000_0020));
                check("timeout_cs", 64'(tgt_cs), 64'(0));
            end
            tick();
        end
        check("timeout_window", 64'((seen >= TO + 1) && (seen <= TO + 3)), 64'(1));
        cpu_valid    = 1'b0;
        exp_rdata    = 32'h0;
        exp_err_addr = 32'h4000_0020;
`else
        seen   = 0;
        pulses = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (cpu_ready || bus_error) pulses++;
            if (tgt_cs != NT'(2)) seen++;
            tick();
        end
        check("wait_forever_pulses", 64'(pulses), 64'(0));
        check("wait_forever_cs", 64'(seen), 64'(0));
        cpu_valid = 1'b0;
`endif
        tick();
        @(negedge clk);
        check("idle_after_wait", 64'(cpu_ready), 64'(0));
        tick();

        for (int n = 0; n < 80; n++) begin
            t = $urandom_range(NT - 1, 0);
            if ($urandom_range(1, 0) == 1) begin
                top = 8'(MATCH_T[t]);
                if (t < 2) top = top | 8'($urandom_range(63, 0));
            end else begin
                top = 8'($urandom_range(255, 0));
            end
            run_txn({top, 24'($urandom)}, 4'($urandom), ($urandom_range(7, 0) == 0),
                    $urandom_range(3, 0));
        end

        // Make err_addr and cpu_rdata nonzero, then reset mid-WAIT.
        run_txn(32'h8100_0000, 4'h0, 1'b0, 0);
        run_txn(32'h0000_0040, 4'h0, 1'b0, 0);
        cpu_valid = 1'b1;
        cpu_addr  = 32'hC100_0000;
        tgt_ready = '0;
        repeat (2) tick();
        reset_n   = 1'b0;
        cpu_valid = 1'b0;
        tick();
        @(negedge clk);
        check_zero_outputs("wait_reset");
        tick();
        reset_n = 1'b1;
        pulses  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cpu_ready) pulses++;
            tick();
        end
        check("no_ready_after_reset", 64'(pulses), 64'(0));
        exp_rdata    = 32'h0;
        exp_err_addr = 32'h0;
        run_txn(32'hC400_0000, 4'h1, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
